// File: rtl/tl_sensor_cond.sv
// Car-sensor conditioning for a two-street traffic light: synchronise, debounce and count
// arrivals per street. Define TL_SENSOR_HOLD_EN to stretch presence by HOLD_CYC after it drops.
module tl_sensor_cond #(
    parameter int unsigned DEB_CYC  = 4,
    parameter int unsigned HOLD_CYC = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sa_raw,
    input  logic       sb_raw,
    input  logic       cnt_clr,
    output logic       Ta,
    output logic       Tb,
    output logic [7:0] ca_cnt,
    output logic [7:0] cb_cnt
);

    localparam logic [3:0] DEB_MAX = 4'(DEB_CYC - 1);
`ifdef TL_SENSOR_HOLD_EN
    localparam logic [7:0] HOLD_LD = 8'(HOLD_CYC);
`endif

    logic [1:0] raw_s;
    logic [1:0] present_s;
    logic [7:0] cnt_s [2];

    assign raw_s = {sb_raw, sa_raw};

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic [1:0] sync_q;
        logic       deb_q;
        logic       deb_d;
        logic [3:0] dcnt_q;
        logic [3:0] dcnt_d;
        logic [7:0] cnt_q;
        logic [7:0] cnt_d;
        logic       out_q;
        logic       out_d;
        logic       rise_s;
`ifdef TL_SENSOR_HOLD_EN
        logic [7:0] hcnt_q;
        logic [7:0] hcnt_d;
`endif

        // Debounce, arrival count, optional hold and the registered lane output.
        always_comb begin
            deb_d  = deb_q;
            dcnt_d = 4'd0;
            if (sync_q[1] == deb_q) begin
                dcnt_d = 4'd0;
            end else if (dcnt_q >= DEB_MAX) begin
                deb_d  = ~deb_q;
                dcnt_d = 4'd0;
            end else begin
                dcnt_d = dcnt_q + 4'd1;
            end

            rise_s = ~deb_q & deb_d;

            // Clear dominates a coincident arrival.
            if (cnt_clr) begin
                cnt_d = 8'd0;
            end else if (rise_s && (cnt_q != 8'hFF)) begin
                cnt_d = cnt_q + 8'd1;
            end else begin
                cnt_d = cnt_q;
            end

`ifdef TL_SENSOR_HOLD_EN
            if (deb_q && !deb_d) begin
                hcnt_d = HOLD_LD;
            end else if (rise_s) begin
                hcnt_d = 8'd0;
            end else if (hcnt_q != 8'd0) begin
                hcnt_d = hcnt_q - 8'd1;
            end else begin
                hcnt_d = hcnt_q;
            end
            out_d = deb_d | (hcnt_d != 8'd0);
`else
            out_d = deb_d;
`endif
        end

        // Lane state; the output is its own flop so Ta/Tb never see a gate after the registers.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync_q <= 2'b00;
                deb_q  <= 1'b0;
                dcnt_q <= 4'd0;
                cnt_q  <= 8'd0;
                out_q  <= 1'b0;
`ifdef TL_SENSOR_HOLD_EN
                hcnt_q <= 8'd0;
`endif
            end else begin
                sync_q <= {sync_q[0], raw_s[gi]};
                deb_q  <= deb_d;
                dcnt_q <= dcnt_d;
                cnt_q  <= cnt_d;
                out_q  <= out_d;
`ifdef TL_SENSOR_HOLD_EN
                hcnt_q <= hcnt_d;
`endif
            end
        end

        assign present_s[gi] = out_q;
        assign cnt_s[gi]     = cnt_q;
    end

    assign Ta     = present_s[0];
    assign Tb     = present_s[1];
    assign ca_cnt = cnt_s[0];
    assign cb_cnt = cnt_s[1];

endmodule

// File: tb/tb_tl_sensor_cond.sv
// Scoreboard bench for tl_sensor_cond: a per-lane reference model predicts each edge's
// outputs, which are queued at drive time and compared once the edge has happened.
module tb_tl_sensor_cond;

    localparam int DEB  = 4;
    localparam int HOLD = 8;
`ifdef TL_SENSOR_HOLD_EN
    localparam bit HOLD_BUILD = 1'b1;
`else
    localparam bit HOLD_BUILD = 1'b0;
`endif

    typedef struct {
        logic s1;
        logic s2;
        logic deb;
        int   run;
        int   hold;
        int   cnt;
        logic out;
    } lane_t;

    typedef struct {
        logic ta;
        logic tb;
        int   ca;
        int   cb;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sa_raw = 1'b0;
    logic       sb_raw = 1'b0;
    logic       cnt_clr = 1'b0;
    logic       Ta;
    logic       Tb;
    logic [7:0] ca_cnt;
    logic [7:0] cb_cnt;

    int    n_checks = 0;
    int    n_errors = 0;
    lane_t la;
    lane_t lb;
    exp_t  sb_q [$];

    tl_sensor_cond #(.DEB_CYC(DEB), .HOLD_CYC(HOLD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sa_raw  (sa_raw),
        .sb_raw  (sb_raw),
        .cnt_clr (cnt_clr),
        .Ta      (Ta),
        .Tb      (Tb),
        .ca_cnt  (ca_cnt),
        .cb_cnt  (cb_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic lane_t lane_next(input lane_t s, input logic r, input logic clr);
        lane_t n;
        n    = s;
        n.s1 = r;
        n.s2 = s.s1;
        if (s.s2 == s.deb) begin
            n.run = 0;
        end else if (s.run + 1 >= DEB) begin
            n.deb = ~s.deb;
            n.run = 0;
        end else begin
            n.run = s.run + 1;
        end
        if (clr) n.cnt = 0;
        else if (!s.deb && n.deb) n.cnt = (s.cnt >= 255) ? 255 : s.cnt + 1;
        if (HOLD_BUILD) begin
            if (s.deb && !n.deb) n.hold = HOLD;
            else if (!s.deb && n.deb) n.hold = 0;
            else if (s.hold > 0) n.hold = s.hold - 1;
            n.out = n.deb || (n.hold > 0);
        end else begin
            n.out = n.deb;
        end
        return n;
    endfunction

    // Drive one cycle of stimulus, queue the prediction, then compare after the edge.
    task automatic step(input logic a, input logic b, input logic clr);
        exp_t e;
        sa_raw  = a;
        sb_raw  = b;
        cnt_clr = clr;
        la      = lane_next(la, a, clr);
        lb      = lane_next(lb, b, clr);
        e.ta    = la.out;
        e.tb    = lb.out;
        e.ca    = la.cnt;
        e.cb    = lb.cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_val("Ta", int'(Ta), int'(e.ta));
        check_val("Tb", int'(Tb), int'(e.tb));
        check_val("ca_cnt", int'(ca_cnt), e.ca);
        check_val("cb_cnt", int'(cb_cnt), e.cb);
    endtask

    task automatic model_reset();
        la = '{default: '0};
        lb = '{default: '0};
    endtask

    initial begin
        logic a;
        logic b;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_Ta", int'(Ta), 0);
        check_val("rst_Tb", int'(Tb), 0);
        check_val("rst_ca", int'(ca_cnt), 0);
        check_val("rst_cb", int'(cb_cnt), 0);
        reset_n = 1'b1;

        // Glitches shorter than the debounce window never reach the output.
        for (int w = 2; w <= DEB - 1; w++) begin
            repeat (w) step(1'b1, 1'b0, 1'b0);
            for (int k = 0; k < 8; k++) begin
                step(1'b0, 1'b0, 1'b0);
                check_val("glitch_Ta", int'(Ta), 0);
            end
            check_val("glitch_ca", int'(ca_cnt), 0);
        end

        // Clean rise: Ta and the arrival count move exactly at edge 2+DEB.
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b0, 1'b0);
            if (k == 5) check_val("rise_e5_Ta", int'(Ta), 0);
            if (k == 6) begin
                check_val("rise_e6_Ta", int'(Ta), 1);
                check_val("rise_e6_ca", int'(ca_cnt), 1);
            end
        end

        // Fall: deb drops at edge 6; the hold build keeps Ta high until edge 14.
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b0, 1'b0);
            if (k == 5)  check_val("fall_e5_Ta", int'(Ta), 1);
            if (k == 6)  check_val("fall_e6_Ta", int'(Ta), HOLD_BUILD ? 1 : 0);
            if (k == 13) check_val("fall_e13_Ta", int'(Ta), HOLD_BUILD ? 1 : 0);
            if (k == 14) check_val("fall_e14_Ta", int'(Ta), 0);
        end

        // Independent random patterns on both lanes.
        a = 1'b0;
        b = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 4) == 0) a = ~a;
            if ($urandom_range(0, 6) == 0) b = ~b;
            step(a, b, 1'b0);
        end
        repeat (30) step(1'b0, 1'b0, 1'b0);

        // Saturate street B's counter, then clear on the same edge as an arrival.
        for (int n = 0; n < 300; n++) begin
            repeat (DEB + 2) step(1'b0, 1'b1, 1'b0);
            repeat (DEB + 2) step(1'b0, 1'b0, 1'b0);
        end
        check_val("sat_cb", int'(cb_cnt), 255);
        repeat (DEB + 1) step(1'b0, 1'b1, 1'b0);
        check_val("sat_hold_cb", int'(cb_cnt), 255);
        step(1'b0, 1'b1, 1'b1);
        check_val("clr_win_cb", int'(cb_cnt), 0);
        check_val("clr_win_Tb", int'(Tb), 1);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        check_val("clr_keep_cb", int'(cb_cnt), 0);
        repeat (20) step(1'b0, 1'b0, 1'b0);

        // Asynchronous reset while Tb is high (mid-hold in the hold build).
        repeat (DEB + 2) step(1'b0, 1'b1, 1'b0);
        if (HOLD_BUILD) repeat (DEB + 4) step(1'b0, 1'b0, 1'b0);
        check_val("pre_rst_Tb", int'(Tb), 1);
        check_val("pre_rst_cb", int'(cb_cnt), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("async_rst_Tb", int'(Tb), 0);
        check_val("async_rst_cb", int'(cb_cnt), 0);
        check_val("async_rst_Ta", int'(Ta), 0);
        check_val("async_rst_ca", int'(ca_cnt), 0);
        sb_raw = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();

        // Restart from deb=0 after reset.
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b1, 1'b0);
            if (k == 5) check_val("restart_e5_Ta", int'(Ta), 0);
            if (k == 6) check_val("restart_e6_Tb", int'(Tb), 1);
        end
        check_val("restart_ca", int'(ca_cnt), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
